riscv_uart_loader: RTL and testbench
====================================

RISCV_UART_LOADER -- requirements
Module: riscv_uart_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit; legal range 4 or more.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, the largest accepted program length in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port x_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx, input, 1 bit: UART serial line, 8N1, idle high, asynchronous to clk.
REQ-006 SHALL have port wr_en, output, 1 bit: one-cycle write strobe to the instruction/data RAM.
REQ-007 SHALL have port wr_addr, output, 32 bits: byte address of the word being written.
REQ-008 SHALL have port wr_data, output, 32 bits: word to write.
REQ-009 SHALL have port core_x_reset, output, 1 bit: active-low reset to the core; low holds the core in reset.
REQ-010 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-011 SHALL have port done, output, 1 bit: load completed successfully (sticky).
REQ-012 SHALL have port err, output, 1 bit: load aborted (sticky).

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (flops reset to 1) before any use.
REQ-014 RX FSM states SHALL be IDLE, START, DATA, STOP; reset state IDLE.
REQ-015 IDLE->START on synchronized rx 1->0; START counts CLKS_PER_BIT/2 cycles, then samples: 0 -> DATA, 1 -> IDLE (glitch, no byte, no error).
REQ-016 DATA SHALL sample rx every CLKS_PER_BIT cycles, 8 samples, LSB first, then go to STOP.
REQ-017 STOP SHALL sample after CLKS_PER_BIT cycles: 1 -> single-cycle internal byte_valid, then IDLE; 0 -> framing error, then IDLE.
REQ-018 Loader FSM states SHALL be LEN, LOAD, DONE, ERR; reset state LEN.
REQ-019 LEN SHALL collect 4 bytes, little-endian, into a 32-bit word count N.
REQ-020 Decision on the 4th LEN byte: N==0 -> DONE; N>MAX_WORDS -> ERR; otherwise LOAD with word index 0.
REQ-021 LOAD SHALL assemble 4 bytes little-endian (first byte = wr_data[7:0]) using a 2-bit byte counter that wraps.
REQ-022 On the cycle after the 4th byte's byte_valid, SHALL assert wr_en for exactly 1 cycle with wr_addr = index*4 and wr_data = the assembled word; index then increments.
REQ-023 After write number N (index reaches N), SHALL enter DONE on the cycle following that wr_en.
REQ-024 A framing error in LEN or LOAD SHALL go to ERR; no further wr_en pulses.
REQ-025 DONE and ERR SHALL be terminal until x_reset; in both, received bytes are ignored and wr_en stays 0.
REQ-026 core_x_reset SHALL be 1 only in DONE, driven from a flop, so it rises 1 cycle after DONE is entered; err keeps the core in reset.
REQ-027 busy SHALL be 1 in LEN once its first byte is received, and throughout LOAD; 0 otherwise.
REQ-028 done = (state==DONE); err = (state==ERR); both registered.
REQ-029 wr_addr and wr_data SHALL hold their last values when wr_en is 0.
REQ-030 Index and N SHALL be 32 bits wide; wr_addr = index shifted left by 2, with no overflow possible under MAX_WORDS.

Reset
REQ-031 x_reset low SHALL asynchronously force: both FSMs to their reset states, all counters to 0, wr_en=0, wr_addr=0, wr_data=0, core_x_reset=0, busy=0, done=0, err=0, synchronizer flops=1.
REQ-032 Reset mid-frame or mid-load SHALL discard partial bytes and words; after release the loader expects a fresh length header.

Verification (CLKS_PER_BIT=4, MAX_WORDS=8)
REQ-033 Send 02 00 00 00, 13 00 00 00, 6F 00 00 00 -> wr_en pulses at addr 0x0 with data 0x00000013, then at addr 0x4 with data 0x0000006F; done=1; core_x_reset rises 1 cycle later.
REQ-034 Send 00 00 00 00 -> done=1, no wr_en, busy never 1 after the 4th byte.
REQ-035 Send 09 00 00 00 -> err=1, core_x_reset stays 0, no wr_en.
REQ-036 Send length 1, then a byte with stop bit 0 -> err=1, no wr_en; later valid bytes ignored.
REQ-037 A 1-cycle low glitch on rx while in IDLE -> no byte accepted, state unchanged.
REQ-038 Pulse x_reset low during the 3rd data byte of a load -> all outputs return to reset values; a subsequent full length-1 load writes addr 0x0 correctly.

Source files
------------

// File: rtl/riscv_uart_loader.sv
// UART boot loader: receives a little-endian word count followed by that many
// little-endian 32-bit words, writes them to RAM from address 0, then releases the core.
module riscv_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic        rx,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_x_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]      MAX_LEN   = 32'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_LEN, LD_LOAD, LD_DONE, LD_ERR} ld_state_t;

    rx_state_t        rx_state, rx_next;
    ld_state_t        ld_state, ld_next;

    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             byte_valid, frame_err;

    logic [1:0]       byte_cnt, byte_cnt_next;
    logic [31:0]      word_buf, assembled, len, index;
    logic             take_byte, busy_next;

    // ---------------- receiver ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) rx_state <= RX_IDLE;
        else          rx_state <= rx_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: if (cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt == BIT_LAST && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (cnt == BIT_LAST) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                RX_START: cnt <= (cnt == HALF_LAST) ? '0 : cnt + 1'b1;
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // ---------------- loader ----------------
    assign take_byte = byte_valid && (ld_state == LD_LEN || ld_state == LD_LOAD);
    assign assembled = {shreg, word_buf[31:8]};

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) ld_state <= LD_LEN;
        else          ld_state <= ld_next;
    end

    always_comb begin
        ld_next       = ld_state;
        byte_cnt_next = take_byte ? byte_cnt + 2'd1 : byte_cnt;
        case (ld_state)
            LD_LEN: begin
                if (frame_err) begin
                    ld_next = LD_ERR;
                end else if (take_byte && byte_cnt == 2'd3) begin
                    if (assembled == 32'd0)     ld_next = LD_DONE;
                    else if (assembled > MAX_LEN) ld_next = LD_ERR;
                    else                         ld_next = LD_LOAD;
                end
            end
            LD_LOAD: begin
                if (frame_err)                     ld_next = LD_ERR;
                else if (wr_en && index == len)    ld_next = LD_DONE;
            end
            default: ld_next = ld_state;
        endcase
        busy_next = (ld_next == LD_LOAD) || (ld_next == LD_LEN && byte_cnt_next != 2'd0);
    end

    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            byte_cnt     <= '0;
            word_buf     <= '0;
            len          <= '0;
            index        <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            core_x_reset <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            wr_en        <= 1'b0;
            busy         <= busy_next;
            done         <= (ld_next == LD_DONE);
            err          <= (ld_next == LD_ERR);
            core_x_reset <= (ld_state == LD_DONE);
            if (take_byte) begin
                byte_cnt <= byte_cnt_next;
                word_buf <= assembled;
                if (byte_cnt == 2'd3) begin
                    if (ld_state == LD_LEN) begin
                        len   <= assembled;
                        index <= '0;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= {index[29:0], 2'b00};
                        wr_data <= assembled;
                        index   <= index + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_uart_loader.sv
// Scoreboard bench for riscv_uart_loader: directed UART frames, expected RAM writes
// queued by the stimulus and compared by an independent negedge monitor.
module tb_riscv_uart_loader;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        x_reset = 1'b0;
    logic        rx = 1'b1;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic        core_x_reset, busy, done, err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  writes_seen = 0;

    riscv_uart_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(8)) dut (
        .clk(clk), .x_reset(x_reset), .rx(rx),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_x_reset(core_x_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected write per wr_en, and times core_x_reset against done.
    initial begin : monitor
        logic prev_done = 1'b0;
        logic prev_wr = 1'b0;
        logic core_pending = 1'b0;
        wr_t  e;
        forever begin
            @(negedge clk);
            if (x_reset) begin
                if (wr_en) begin
                    writes_seen++;
                    check("wr_en_pulse_width", {31'd0, prev_wr}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_wr_en", {31'd0, wr_en}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_data", wr_data, e.data);
                    end
                end
                if (core_pending) begin
                    check("core_x_reset_rise", {31'd0, core_x_reset}, 32'd1);
                    core_pending = 1'b0;
                end
                if (done && !prev_done) begin
                    check("core_x_reset_at_done", {31'd0, core_x_reset}, 32'd0);
                    core_pending = 1'b1;
                end
                prev_done = done;
                prev_wr   = wr_en;
            end else begin
                prev_done    = 1'b0;
                prev_wr      = 1'b0;
                core_pending = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_bit, CPB);
        hold(1'b1, 2 * CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},        {31'd0, wr_en},        32'd0);
        check({tag, "_wr_addr"},      wr_addr,               32'd0);
        check({tag, "_wr_data"},      wr_data,               32'd0);
        check({tag, "_core_x_reset"}, {31'd0, core_x_reset}, 32'd0);
        check({tag, "_busy"},         {31'd0, busy},         32'd0);
        check({tag, "_done"},         {31'd0, done},         32'd0);
        check({tag, "_err"},          {31'd0, err},          32'd0);
    endtask

    task automatic do_reset(input string tag);
        check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
        exp_q.delete();
        x_reset = 1'b0;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(tag);
        x_reset = 1'b1;
        hold(1'b1, 2 * CPB);
    endtask

    initial begin : stim
        int w0;
        int busy_hi;
        @(posedge clk);
        #1;

        // Two-word program: 0x13 at 0x0, 0x6F at 0x4.
        do_reset("rst0");
        check("idle_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h02, 1'b1);
        check("len_busy_after_first", {31'd0, busy}, 32'd1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("load_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back('{addr: 32'h0, data: 32'h0000_0013});
        exp_q.push_back('{addr: 32'h4, data: 32'h0000_006F});
        send_word(32'h0000_0013);
        check("mid_load_busy", {31'd0, busy}, 32'd1);
        check("mid_load_done", {31'd0, done}, 32'd0);
        send_word(32'h0000_006F);
        hold(1'b1, 4);
        check("prog_done", {31'd0, done}, 32'd1);
        check("prog_err", {31'd0, err}, 32'd0);
        check("prog_busy", {31'd0, busy}, 32'd0);
        check("prog_core", {31'd0, core_x_reset}, 32'd1);
        w0 = writes_seen;
        send_word(32'hCAFE_F00D);
        check("done_ignores_bytes", writes_seen - w0, 32'd0);

        // Zero-length program.
        do_reset("rst1");
        w0 = writes_seen;
        send_word(32'h0);
        busy_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        check("len0_busy_cycles", busy_hi, 32'd0);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_core", {31'd0, core_x_reset}, 32'd1);
        check("len0_writes", writes_seen - w0, 32'd0);
        @(posedge clk);
        #1;

        // Length above MAX_WORDS.
        do_reset("rst2");
        w0 = writes_seen;
        send_word(32'd9);
        send_word(32'h1234_5678);
        check("len9_err", {31'd0, err}, 32'd1);
        check("len9_done", {31'd0, done}, 32'd0);
        check("len9_core", {31'd0, core_x_reset}, 32'd0);
        check("len9_busy", {31'd0, busy}, 32'd0);
        check("len9_writes", writes_seen - w0, 32'd0);

        // Boundary: length exactly MAX_WORDS is accepted.
        do_reset("rst3");
        send_word(32'd8);
        check("len8_busy", {31'd0, busy}, 32'd1);
        check("len8_err", {31'd0, err}, 32'd0);

        // Framing error during load.
        do_reset("rst4");
        w0 = writes_seen;
        send_word(32'd1);
        send_byte(8'hAA, 1'b0);
        check("frame_err_err", {31'd0, err}, 32'd1);
        send_word(32'h4433_2211);
        check("frame_err_writes", writes_seen - w0, 32'd0);
        check("frame_err_err_sticky", {31'd0, err}, 32'd1);
        check("frame_err_done", {31'd0, done}, 32'd0);
        check("frame_err_core", {31'd0, core_x_reset}, 32'd0);

        // One-cycle glitch in IDLE, then a length-1 load must stay aligned.
        do_reset("rst5");
        hold(1'b0, 1);
        hold(1'b1, 20);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_err", {31'd0, err}, 32'd0);
        check("glitch_done", {31'd0, done}, 32'd0);
        w0 = writes_seen;
        send_word(32'd1);
        exp_q.push_back('{addr: 32'h0, data: 32'hDEAD_BEEF});
        send_word(32'hDEAD_BEEF);
        hold(1'b1, 4);
        check("glitch_load_writes", writes_seen - w0, 32'd1);
        check("glitch_load_done", {31'd0, done}, 32'd1);

        // Reset in the middle of the third data byte.
        do_reset("rst6");
        send_word(32'd2);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        #2;
        x_reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        x_reset = 1'b1;
        hold(1'b1, 2 * CPB);
        check("post_rst_pending", exp_q.size(), 32'd0);
        w0 = writes_seen;
        send_word(32'd1);
        exp_q.push_back('{addr: 32'h0, data: 32'h1234_5678});
        send_word(32'h1234_5678);
        hold(1'b1, 4);
        check("post_rst_writes", writes_seen - w0, 32'd1);
        check("post_rst_done", {31'd0, done}, 32'd1);
        check("post_rst_pending_end", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
